// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the 4-bit multiply-accumulate block.
//   - default MAX_TERMS / ACC_W constants
//   - FSM state encoding (ACCUM, DRAIN, HOLD)
package mac_pkg;

    localparam int MAC_MAX_TERMS_DEF = 16;
    localparam int MAC_ACC_W_DEF     = 12;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,   // accepting operand beats
        DRAIN = 2'd1,   // final term is in stage 1, being summed
        HOLD  = 2'd2    // result presented until the consumer takes it
    } state_t;

endpackage

// File: rtl/wallace_4bit.sv
// wallace_4bit: combinational 4x4 unsigned multiplier.
//   a       : input  [3:0] multiplicand
//   b       : input  [3:0] multiplier
//   product : output [7:0] a*b
// Partial products are reduced by two carry-save rows and one final adder.
module wallace_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product
);

    logic [7:0] pp [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pp
            assign pp[gi] = {4'b0000, a & {4{b[gi]}}} << gi;
        end
    endgenerate

    logic [7:0] s1;
    logic [7:0] c1;
    logic [7:0] s2;
    logic [7:0] c2;

    // 3:2 compression of rows 0..2, then of the result with row 3.
    // The true product fits 8 bits, so dropping bits above 7 is safe.
    assign s1 = pp[0] ^ pp[1] ^ pp[2];
    assign c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    assign s2 = s1 ^ c1 ^ pp[3];
    assign c2 = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;

    assign product = s2 + c2;

endmodule

// File: rtl/mac_accum_4bit.sv
// mac_accum_4bit: packetised sum of 4-bit unsigned products.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand beat handshake (a, b, in_last)
//   out_valid/out_ready : result handshake (acc_out, term_cnt)
//   acc_out             : sum of a*b over the packet
//   term_cnt            : number of terms summed
// Stage 1 registers the operands, stage 2 adds their product into the
// accumulator. A packet ends on in_last or when MAX_TERMS beats are taken.
module mac_accum_4bit
    import mac_pkg::*;
#(
    parameter int MAX_TERMS = MAC_MAX_TERMS_DEF,
    parameter int ACC_W     = MAC_ACC_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [3:0]                     a,
    input  logic [3:0]                     b,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_W-1:0]               acc_out,
    output logic [$clog2(MAX_TERMS+1)-1:0] term_cnt
);

    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    state_t           state_reg;
    state_t           state_next;
    logic [3:0]       a_reg;
    logic [3:0]       b_reg;
    logic             last_reg;
    logic             s1_valid_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       product;

    logic             accept;
    logic [CNT_W:0]   accepted_total;
    logic             forced_last;
    logic             pkt_end;

    assign in_ready = ~rst & (state_reg == ACCUM);
    assign accept   = in_valid & in_ready;

    // Beats taken so far including this one: summed terms plus the one
    // possibly still sitting in stage 1.
    assign accepted_total = {1'b0, cnt_reg}
                          + {{CNT_W{1'b0}}, s1_valid_reg}
                          + {{CNT_W{1'b0}}, 1'b1};
    assign forced_last    = (accepted_total == (CNT_W+1)'(MAX_TERMS));
    assign pkt_end        = accept & (in_last | forced_last);

    // The FSM decides end-of-packet at acceptance so in_ready drops on the
    // very next cycle; the registered last flag is kept only for visibility.
    logic unused_last;
    assign unused_last = last_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (pkt_end)   state_next = DRAIN;
            DRAIN:                  state_next = HOLD;
            HOLD:    if (out_ready) state_next = ACCUM;
            default:                state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    // Stage 1: operand capture, only on an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg        <= '0;
            b_reg        <= '0;
            last_reg     <= 1'b0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                a_reg    <= a;
                b_reg    <= b;
                last_reg <= in_last | forced_last;
            end
        end
    end

    wallace_4bit u_mult (
        .a       (a_reg),
        .b       (b_reg),
        .product (product)
    );

    // Stage 2: the first term of a packet loads, later terms add.
    // Idle stage-1 slots leave the accumulator untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (s1_valid_reg) begin
            if (cnt_reg == '0) begin
                acc_reg <= {{(ACC_W-8){1'b0}}, product};
            end else begin
                acc_reg <= acc_reg + {{(ACC_W-8){1'b0}}, product};
            end
            cnt_reg <= cnt_reg + 1'b1;
        end else if ((state_reg == HOLD) && out_ready) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end
    end

    assign out_valid = (state_reg == HOLD);
    assign acc_out   = acc_reg;
    assign term_cnt  = cnt_reg;

endmodule

// File: tb/tb_mac_accum_4bit.sv
module tb_mac_accum_4bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] acc_out;
    logic [4:0]  term_cnt;

    mac_accum_4bit #(.MAX_TERMS(16), .ACC_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .term_cnt  (term_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] acc;
        logic [4:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Offer one beat; returns #1 after the edge that samples it.
    task automatic beat(input logic [3:0] av, input logic [3:0] bv, input logic last);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic wait_out(output bit ok);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        ok = out_valid;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({in_ready, out_valid, acc_out, term_cnt} !== 19'd0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b acc=%0d cnt=%0d, want all 0",
                     in_ready, out_valid, acc_out, term_cnt);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        $display("[TB] reset check done");
    endtask

    task automatic test_back_to_back();
        logic [3:0] av [6] = '{4'd3, 4'd5, 4'd4, 4'd5, 4'd7, 4'd3};
        logic [3:0] bv [6] = '{4'd2, 4'd3, 4'd2, 4'd2, 4'd2, 4'd1};
        exp_t e;
        int   sum = 0;
        for (int i = 0; i < 6; i++) begin
            sum += av[i] * bv[i];
            beat(av[i], bv[i], i == 5);
        end
        sb.push_back('{acc: 12'(sum), cnt: 5'd6});
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_early_valid: got out_valid=%b one edge after last, want 0", out_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_valid_latency: got out_valid=%b two edges after last, want 1", out_valid);
        end else begin
            e = sb.pop_front();
            tests++;
            if (acc_out !== e.acc || term_cnt !== e.cnt) begin
                fails++;
                $display("FAIL b2b_result: got acc=%0d cnt=%0d want acc=%0d cnt=%0d",
                         acc_out, term_cnt, e.acc, e.cnt);
            end
        end
        release_out();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_release: got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
        end
        $display("[TB] back_to_back packet sum=%0d", sum);
    endtask

    task automatic test_single();
        logic [3:0] av [2] = '{4'd15, 4'd0};
        logic [3:0] bv [2] = '{4'd15, 4'd9};
        exp_t e;
        bit   ok;
        for (int i = 0; i < 2; i++) begin
            beat(av[i], bv[i], 1'b1);
            sb.push_back('{acc: 12'(av[i] * bv[i]), cnt: 5'd1});
            wait_out(ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL single_timeout[%0d]: got out_valid=0 want 1", i);
            end else begin
                e = sb.pop_front();
                tests++;
                if (acc_out !== e.acc || term_cnt !== e.cnt) begin
                    fails++;
                    $display("FAIL single_result[%0d]: got acc=%0d cnt=%0d want acc=%0d cnt=%0d",
                             i, acc_out, term_cnt, e.acc, e.cnt);
                end
            end
            release_out();
            $display("[TB] single beat (%0d,%0d)", av[i], bv[i]);
        end
    endtask

    task automatic test_forced_last();
        exp_t e;
        bit   ok;
        int   sum = 0;
        for (int i = 0; i < 16; i++) begin
            sum += 225;
            beat(4'd15, 4'd15, 1'b0);
        end
        sb.push_back('{acc: 12'(sum), cnt: 5'd16});
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL forced_ready_drop: got in_ready=%b after 16th beat want 0", in_ready);
        end
        wait_out(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL forced_timeout: got out_valid=0 want 1");
        end else begin
            e = sb.pop_front();
            tests++;
            if (acc_out !== e.acc || term_cnt !== e.cnt) begin
                fails++;
                $display("FAIL forced_result: got acc=%0d cnt=%0d want acc=%0d cnt=%0d",
                         acc_out, term_cnt, e.acc, e.cnt);
            end
        end
        release_out();
        $display("[TB] forced last packet sum=%0d", sum);
    endtask

    task automatic test_hold();
        exp_t e;
        bit   ok;
        beat(4'd6, 4'd7, 1'b1);
        sb.push_back('{acc: 12'd42, cnt: 5'd1});
        wait_out(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL hold_timeout: got out_valid=0 want 1");
        end else begin
            e = sb.pop_front();
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (acc_out !== e.acc || term_cnt !== e.cnt || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL hold_stable[%0d]: got acc=%0d cnt=%0d rdy=%b ov=%b want acc=%0d cnt=%0d rdy=0 ov=1",
                             i, acc_out, term_cnt, in_ready, out_valid, e.acc, e.cnt);
                end
                idle_cycle();
            end
        end
        release_out();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
        end
        $display("[TB] hold with out_ready low 5 cycles");
    endtask

    task automatic test_gaps();
        exp_t e;
        bit   ok;
        beat(4'd2, 4'd2, 1'b0);
        idle_cycle();
        beat(4'd3, 4'd3, 1'b1);
        idle_cycle();
        sb.push_back('{acc: 12'd13, cnt: 5'd2});
        wait_out(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL gaps_timeout: got out_valid=0 want 1");
        end else begin
            e = sb.pop_front();
            tests++;
            if (acc_out !== e.acc || term_cnt !== e.cnt) begin
                fails++;
                $display("FAIL gaps_result: got acc=%0d cnt=%0d want acc=%0d cnt=%0d",
                         acc_out, term_cnt, e.acc, e.cnt);
            end
        end
        release_out();
        $display("[TB] gapped packet");
    endtask

    task automatic test_rst_mid();
        exp_t e;
        bit   ok;
        beat(4'd3, 4'd2, 1'b0);
        beat(4'd5, 4'd3, 1'b0);
        beat(4'd4, 4'd2, 1'b0);
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({in_ready, out_valid, acc_out, term_cnt} !== 19'd0) begin
            fails++;
            $display("FAIL rst_mid_async: got rdy=%b ov=%b acc=%0d cnt=%0d want all 0",
                     in_ready, out_valid, acc_out, term_cnt);
        end
        @(posedge clk); #1 rst = 1'b0;
        beat(4'd1, 4'd1, 1'b1);
        sb.push_back('{acc: 12'd1, cnt: 5'd1});
        wait_out(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rst_mid_timeout: got out_valid=0 want 1");
        end else begin
            e = sb.pop_front();
            tests++;
            if (acc_out !== e.acc || term_cnt !== e.cnt) begin
                fails++;
                $display("FAIL rst_mid_result: got acc=%0d cnt=%0d want acc=%0d cnt=%0d",
                         acc_out, term_cnt, e.acc, e.cnt);
            end
        end
        // Reset while holding a result discards it at once.
        #1 rst = 1'b1;
        sb.delete();
        #1;
        tests++;
        if ({in_ready, out_valid, acc_out, term_cnt} !== 19'd0) begin
            fails++;
            $display("FAIL rst_hold_async: got rdy=%b ov=%b acc=%0d cnt=%0d want all 0",
                     in_ready, out_valid, acc_out, term_cnt);
        end
        @(posedge clk); #1 rst = 1'b0;
        $display("[TB] reset mid-packet and in hold");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_forced_last();
        test_hold();
        test_gaps();
        test_rst_mid();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_accum_4bit.md
MAC_ACCUM_4BIT -- requirements
Module: mac_accum_4bit

Interface
REQ-001 SHALL have parameter MAX_TERMS, default 16: maximum products summed per packet.
REQ-002 SHALL have parameter ACC_W, default 12: accumulator width; SHALL satisfy ACC_W >= 8 + ceil(log2(MAX_TERMS)).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port a  input  4  unsigned multiplicand.
REQ-008 SHALL have port b  input  4  unsigned multiplier.
REQ-009 SHALL have port in_last  input  1  beat is the final term of its packet.
REQ-010 SHALL have port out_valid  output  1  packet result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port acc_out  output  ACC_W  sum of a*b over the packet.
REQ-013 SHALL have port term_cnt  output  ceil(log2(MAX_TERMS+1))  number of terms summed.

Function
REQ-014 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both high; a, b and in_last are sampled only then.
REQ-015 Stage 1 SHALL register a, b and in_last; the product SHALL come from the registered operands.
REQ-016 Stage 2 SHALL add the 8-bit zero-extended product to the accumulator one edge after stage 1 captures.
REQ-017 The first term of a packet SHALL load the accumulator with the product, with no stale sum added.
REQ-018 States SHALL be ACCUM, DRAIN and HOLD; in_ready SHALL be high only in ACCUM with rst low.
REQ-019 ACCUM SHALL go to DRAIN on an accepted beat with in_last high, or on the accepted beat that makes the term count reach MAX_TERMS (forced last).
REQ-020 DRAIN SHALL go to HOLD unconditionally after one cycle; out_valid SHALL be high exactly in HOLD.
REQ-021 out_valid SHALL therefore rise two edges after the edge that accepted the last beat.
REQ-022 HOLD SHALL go to ACCUM on an edge where out_ready is high; the accumulator and count SHALL clear on that edge.
REQ-023 acc_out and term_cnt SHALL be stable throughout HOLD, regardless of how long out_ready stays low.
REQ-024 Within a packet, back-to-back beats SHALL be accepted at one per cycle with no bubbles.
REQ-025 Gaps in in_valid SHALL NOT alter the accumulator; idle stage-1 slots SHALL add nothing.
REQ-026 Overflow cannot occur: the maximum sum is 225*MAX_TERMS, which fits ACC_W by REQ-002.
REQ-027 acc_out SHALL equal the accumulator register in all states; outside HOLD its value is don't-care to consumers.

Reset
REQ-028 While rst is high, the state SHALL be ACCUM, and in_ready, out_valid, acc_out, term_cnt and all stage-1 registers SHALL be 0.
REQ-029 Asserting rst mid-packet or in HOLD SHALL discard all partial or pending results immediately, without waiting for a clock.
REQ-030 The first beat accepted after rst deasserts SHALL start a new packet.

Structure
REQ-031 Package mac_pkg SHALL hold the state enum and the default MAX_TERMS and ACC_W constants.
REQ-032 The product SHALL be formed by one instance of the existing wallace_4bit sub-module (ports a, b, product), fed by the stage-1 registers.
REQ-033 No other sub-modules SHALL be used.

Verification
REQ-034 Beats (3,2),(5,3),(4,2),(5,2),(7,2),(3,1) back-to-back, with last on the sixth beat -> out_valid high two edges later, acc_out=56, term_cnt=6.
REQ-035 Single beat (15,15) with last -> acc_out=225, term_cnt=1; then beat (0,9) with last -> acc_out=0, term_cnt=1 (no stale sum).
REQ-036 Sixteen beats of (15,15) with in_last never high -> forced last, acc_out=3600, term_cnt=16, in_ready low from the edge after the 16th beat.
REQ-037 In HOLD with out_ready held low for 5 cycles -> acc_out/term_cnt stable, in_ready=0; out_ready high -> back to ACCUM and in_ready=1 on the next cycle.
REQ-038 in_valid toggling 1,0,1,0 over beats (2,2),(3,3) with last on the second beat -> acc_out=13, term_cnt=2.
REQ-039 rst pulse after 3 of 6 beats -> all outputs 0 at once; a following packet (1,1) with last -> acc_out=1, term_cnt=1.
